// File: rtl/conv2d_transpose_shift_mc.sv
// Multi-channel transposed convolution with power-of-two weight codes,
// cleared wide accumulators and a saturated registered read port.
module conv2d_transpose_shift_mc #(
   parameter int PIXEL            = 10,
   parameter int KERNEL           = 3,
   parameter int STRIDE           = 3,
   parameter int C_IN             = 2,
   parameter int C_OUT            = 2,
   parameter int INTEGER_WIDTH    = 10,
   parameter int FRACTION_WIDTH   = 10,
   parameter int KERNEL_BIT_WIDTH = 6,
   parameter int ACC_GUARD        = 12,
   localparam int W    = INTEGER_WIDTH + FRACTION_WIDTH,
   localparam int O    = STRIDE * (PIXEL - 1) + KERNEL,
   localparam int NKER = C_OUT * C_IN * KERNEL * KERNEL,
   localparam int NACC = C_OUT * O * O,
   localparam int KA_W = (NKER > 1) ? $clog2(NKER) : 1,
   localparam int OA_W = (NACC > 1) ? $clog2(NACC) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [W-1:0]         in_data,
   output logic [KA_W-1:0]             kernel_addr,
   input  logic [KERNEL_BIT_WIDTH-1:0] kernel_data,
   input  logic [OA_W-1:0]             out_addr,
   output logic signed [W-1:0]         out_data,
   output logic                        done
);
   localparam int KB    = KERNEL_BIT_WIDTH;
   localparam int ACC_W = W + 2**(KB-2) - 1 + ACC_GUARD;
   localparam int NPIX  = C_IN * PIXEL * PIXEL;
   localparam int PA_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int CO_W  = (C_OUT > 1) ? $clog2(C_OUT) : 1;
   localparam int CI_W  = (C_IN > 1) ? $clog2(C_IN) : 1;
   localparam int N_W   = (PIXEL > 1) ? $clog2(PIXEL) : 1;
   localparam int K_W   = (KERNEL > 1) ? $clog2(KERNEL) : 1;

   localparam logic signed [ACC_W-1:0] SMAX =
      {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN =
      {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [KB-1:0] ZERO_CODE = {1'b1, {(KB-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CLEAR, S_ADDR, S_READ, S_ACC, S_DONE
   } state_t;

   state_t                  state_q;
   logic [PA_W-1:0]         pcnt_q;
   logic [OA_W-1:0]         ccnt_q;
   logic [CO_W-1:0]         co_q;
   logic [CI_W-1:0]         ci_q;
   logic [N_W-1:0]          i_q, j_q;
   logic [K_W-1:0]          ki_q, kj_q;
   logic [KB-1:0]           w_q;
   logic signed [W-1:0]     x_q;
   logic                    in_ready_q, done_q;
   logic signed [W-1:0]     out_q;

   logic signed [W-1:0]     pix_mem [NPIX];
   logic signed [ACC_W-1:0] acc_mem [NACC];

   logic                    accept, last_beat;
   logic [PA_W-1:0]         bidx, pix_raddr;
   logic [OA_W-1:0]         acc_addr;
   logic signed [ACC_W-1:0] xe, mag, term, acc_sum, rd_val;
   logic signed [W-1:0]     sat_val;
   logic                    c1, c2, c3, c4, c5, last_tap;

   assign in_ready  = in_ready_q;
   assign done      = done_q;
   assign out_data  = out_q;

   assign accept    = in_valid & in_ready_q;
   assign bidx      = (state_q == S_LOAD) ? pcnt_q : '0;
   assign last_beat = int'(bidx) == NPIX - 1;

   assign pix_raddr = PA_W'(int'(ci_q) * PIXEL * PIXEL
                      + int'(i_q) * PIXEL + int'(j_q));
   assign acc_addr  = OA_W'((int'(co_q) * O + STRIDE * int'(i_q)
                      + int'(ki_q)) * O + STRIDE * int'(j_q) + int'(kj_q));
   assign kernel_addr = KA_W'(((int'(co_q) * C_IN + int'(ci_q)) * KERNEL
                      + int'(ki_q)) * KERNEL + int'(kj_q));

   assign c1       = kj_q == K_W'(KERNEL - 1);
   assign c2       = c1 && ki_q == K_W'(KERNEL - 1);
   assign c3       = c2 && j_q == N_W'(PIXEL - 1);
   assign c4       = c3 && i_q == N_W'(PIXEL - 1);
   assign c5       = c4 && ci_q == CI_W'(C_IN - 1);
   assign last_tap = c5 && co_q == CO_W'(C_OUT - 1);

   // Pixel keeps its binary point; the code only scales by 2^(+/-s).
   always_comb begin
      xe = {{(ACC_W-W){x_q[W-1]}}, x_q};
      if (w_q[KB-2]) mag = xe >>> w_q[KB-3:0];
      else           mag = xe <<< w_q[KB-3:0];
      if (w_q == ZERO_CODE) term = '0;
      else if (w_q[KB-1])   term = -mag;
      else                  term = mag;
      acc_sum = acc_mem[acc_addr] + term;
   end

   always_comb begin
      rd_val = (int'(out_addr) < NACC) ? acc_mem[out_addr] : '0;
      if (rd_val > SMAX)      sat_val = SMAX[W-1:0];
      else if (rd_val < SMIN) sat_val = SMIN[W-1:0];
      else                    sat_val = rd_val[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (accept) pix_mem[bidx] <= in_data;
      if (state_q == S_CLEAR)    acc_mem[ccnt_q]   <= '0;
      else if (state_q == S_ACC) acc_mem[acc_addr] <= acc_sum;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pcnt_q     <= '0;
         ccnt_q     <= '0;
         co_q       <= '0;
         ci_q       <= '0;
         i_q        <= '0;
         j_q        <= '0;
         ki_q       <= '0;
         kj_q       <= '0;
         w_q        <= '0;
         x_q        <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         out_q      <= '0;
      end else begin
         out_q <= (state_q == S_DONE) ? sat_val : '0;
         unique case (state_q)
            S_IDLE, S_LOAD, S_DONE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  done_q  <= 1'b0;
                  pcnt_q  <= last_beat ? '0 : bidx + 1'b1;
                  state_q <= last_beat ? S_CLEAR : S_LOAD;
                  if (last_beat) in_ready_q <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (ccnt_q == OA_W'(NACC - 1)) begin
                  ccnt_q  <= '0;
                  state_q <= S_ADDR;
               end else begin
                  ccnt_q  <= ccnt_q + 1'b1;
               end
            end
            S_ADDR: state_q <= S_READ;
            S_READ: begin
               w_q     <= kernel_data;
               x_q     <= pix_mem[pix_raddr];
               state_q <= S_ACC;
            end
            S_ACC: begin
               kj_q <= c1 ? '0 : kj_q + 1'b1;
               if (c1) ki_q <= c2 ? '0 : ki_q + 1'b1;
               if (c2) j_q  <= c3 ? '0 : j_q + 1'b1;
               if (c3) i_q  <= c4 ? '0 : i_q + 1'b1;
               if (c4) ci_q <= c5 ? '0 : ci_q + 1'b1;
               if (c5) co_q <= last_tap ? '0 : co_q + 1'b1;
               if (last_tap) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  in_ready_q <= 1'b1;
               end else begin
                  state_q    <= S_ADDR;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv2d_transpose_shift_mc.sv
// Bench for conv2d_transpose_shift_mc: directed and random frames against
// a gather-form reference model, with latency and tap-order checks.
module tb_conv2d_transpose_shift_mc;
   localparam int N = 2, K = 3, S = 2, CI = 2, CO = 2;
   localparam int O = S * (N - 1) + K;
   localparam int NPIX = CI * N * N;
   localparam int NKER = CO * CI * K * K;
   localparam int NACC = CO * O * O;
   localparam int NTAP = CO * CI * N * N * K * K;
   localparam int LAT = 1 + NACC + 3 * NTAP;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_data;
   logic [5:0]  kernel_addr;
   logic [5:0]  kernel_data;
   logic [5:0]  out_addr;
   logic [19:0] out_data;
   logic        done;

   logic signed [19:0] pix [NPIX];
   logic [5:0]         rom [NKER];
   logic [19:0]        exp_o [NACC];
   logic [19:0]        prev_exp [NACC];
   bit                 have_prev;
   int                 vectors, miscompares;

   conv2d_transpose_shift_mc #(
      .PIXEL(N), .KERNEL(K), .STRIDE(S), .C_IN(CI), .C_OUT(CO)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .kernel_addr(kernel_addr),
      .kernel_data(kernel_data), .out_addr(out_addr),
      .out_data(out_data), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) kernel_data <= rom[kernel_addr];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [19:0] fx(input longint v);
      return v[19:0];
   endfunction

   function automatic longint tap_term(input longint x, input logic [5:0] w);
      longint m;
      int sh;
      if (w == 6'b100000) return 0;
      sh = int'(w[3:0]);
      m = w[4] ? (x >>> sh) : (x <<< sh);
      return w[5] ? -m : m;
   endfunction

   // Each output gathers every input pixel whose stride grid covers it.
   function automatic void compute_expected();
      longint s;
      int ki, kj;
      for (int co = 0; co < CO; co++)
         for (int r = 0; r < O; r++)
            for (int c = 0; c < O; c++) begin
               s = 0;
               for (int ci = 0; ci < CI; ci++)
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++) begin
                        ki = r - S * i;
                        kj = c - S * j;
                        if (ki >= 0 && ki < K && kj >= 0 && kj < K)
                           s += tap_term(longint'(pix[ci*N*N + i*N + j]),
                                         rom[((co*CI + ci)*K + ki)*K + kj]);
                     end
               if (s > 524287) s = 524287;
               if (s < -524288) s = -524288;
               exp_o[(co*O + r)*O + c] = fx(s);
            end
   endfunction

   function automatic int exp_kaddr(input int t);
      int kj, ki, ci, co;
      kj = t % K;
      ki = (t / K) % K;
      ci = (t / (K*K*N*N)) % CI;
      co = t / (K*K*N*N*CI);
      return ((co*CI + ci)*K + ki)*K + kj;
   endfunction

   task automatic run_frame(input string tag, input int abort_at);
      int lat;
      int k;
      compute_expected();
      for (int b = 0; b < NPIX; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         chk({tag, ".rdy_load"}, in_ready, 1);
         in_valid = 1'b1;
         in_data  = pix[b];
         if (b == 0) out_addr = 6'd12;
         @(posedge clk); #1;
         if (b == 0 && have_prev) begin
            chk({tag, ".done_drop"}, done, 0);
            chk({tag, ".old_read"}, out_data, prev_exp[12]);
         end
      end
      lat = 1;
      chk({tag, ".rdy_drop"}, in_ready, 0);
      while (lat < 3000) begin
         k = lat - 1;
         if (k >= LAT - 15) in_valid = 1'b0;
         else begin
            in_valid = 1'b1;
            in_data  = 20'($urandom);
         end
         @(posedge clk); #1;
         lat++;
         k = lat - 1;
         if (abort_at != 0 && lat == abort_at) begin
            in_valid = 1'b0;
            return;
         end
         if (k >= NACC && (k - NACC) % 3 == 0 && (k - NACC) / 3 < NTAP)
            chk($sformatf("%s.kaddr[%0d]", tag, (k - NACC) / 3),
                kernel_addr, exp_kaddr((k - NACC) / 3));
         if (k == 5) chk({tag, ".out_busy"}, out_data, 0);
         if (done) break;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, lat, LAT);
      chk({tag, ".rdy_done"}, in_ready, 1);
      for (int a = 0; a < NACC + 3; a++) begin
         out_addr = (a == NACC + 2) ? 6'd63 : 6'(a);
         @(posedge clk); #1;
         chk($sformatf("%s.out[%0d]", tag, out_addr), out_data,
             (a < NACC) ? exp_o[a] : 20'd0);
      end
      prev_exp  = exp_o;
      have_prev = 1'b1;
   endtask

   task automatic read_chk(input string tag, input int a, input logic [19:0] v);
      out_addr = 6'(a);
      @(posedge clk); #1;
      chk(tag, out_data, v);
   endtask

   task automatic clear_frame();
      for (int b = 0; b < NPIX; b++) pix[b] = '0;
      for (int q = 0; q < NKER; q++) rom[q] = 6'b100000;
   endtask

   task automatic rand_frame();
      int v;
      for (int b = 0; b < NPIX; b++) begin
         v = int'($urandom_range(0, 8191)) - 4096;
         pix[b] = v[19:0];
      end
      for (int q = 0; q < NKER; q++) begin
         if ($urandom_range(0, 5) == 0) rom[q] = 6'b100000;
         else begin
            rom[q][5]   = 1'($urandom_range(0, 1));
            rom[q][4]   = 1'($urandom_range(0, 1));
            rom[q][3:0] = 4'($urandom_range(0, 4));
         end
      end
   endtask

   task automatic single_tap(input string tag, input longint x,
                             input logic [5:0] code, input longint res);
      clear_frame();
      pix[0] = x[19:0];
      rom[0] = code;
      run_frame(tag, 0);
      read_chk({tag, ".tap"}, 0, fx(res));
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      have_prev = 1'b0;
      reset = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_addr = '0;
      clear_frame();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", in_ready, 0);
      chk("rst.done", done, 0);
      chk("rst.kaddr", kernel_addr, 0);
      chk("rst.out", out_data, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("rel.in_ready", in_ready, 1);
      chk("rel.done", done, 0);

      pix[0] = 20'sd1024; pix[1] = 20'sd2048;
      pix[2] = -20'sd1024; pix[3] = 20'sd512;
      for (int q = 0; q < K*K; q++) rom[q] = 6'b000000;
      run_frame("overlap", 0);
      read_chk("overlap.0_2", 2, fx(3072));
      read_chk("overlap.2_2", 12, fx(2560));
      read_chk("overlap.4_4", 24, fx(512));

      single_tap("div2", -3072, 6'b010001, -1536);
      single_tap("negx2", -3072, 6'b100001, 6144);
      single_tap("zero", -3072, 6'b100000, 0);
      single_tap("floor", -1, 6'b010001, -1);
      single_tap("sat_pos", 512000, 6'b000010, 524287);
      single_tap("sat_neg", -512000, 6'b000010, -524288);

      clear_frame();
      for (int b = 0; b < N*N; b++) begin
         pix[b] = 20'sd1024;
         pix[N*N + b] = 20'sd2048;
      end
      for (int q = 0; q < K*K; q++) begin
         rom[q] = 6'b000000;
         rom[3*K*K + q] = 6'b000000;
      end
      run_frame("chan", 0);
      read_chk("chan.p0_corner", 0, fx(1024));
      read_chk("chan.p0_center", 12, fx(4096));
      read_chk("chan.p1_corner", 25, fx(2048));
      read_chk("chan.p1_center", 37, fx(8192));

      for (int f = 0; f < 3; f++) begin
         rand_frame();
         run_frame($sformatf("rand%0d", f), 0);
      end

      rand_frame();
      run_frame("abort", 200);
      reset = 1'b0;
      #1;
      chk("midrst.done", done, 0);
      chk("midrst.in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("midrst.in_ready_hold", in_ready, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst.in_ready_rel", in_ready, 1);
      chk("midrst.done_rel", done, 0);
      have_prev = 1'b0;
      rand_frame();
      run_frame("after_rst", 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/conv2d_transpose_shift_mc.md
# conv2d_transpose_shift_mc

Multi-channel transposed-convolution engine with shift-only (power-of-two) weights, the parametrised successor of the single-channel stride-3 shift convolver in the decoder datapath. It accepts a C_IN-channel N×N fixed-point feature map over a valid/ready stream and fetches signed shift-code weights from an external kernel ROM port. It accumulates C_OUT output planes of size O×O, O = STRIDE·(N−1)+K, in internal wide accumulators and exposes them through a registered random-access read port with saturated readout. New over the previous generation: channel loops, configurable stride and kernel, an explicit zero-weight code, an on-chip accumulator clear, and saturating output.

## Interface
- PIXEL, 10: input plane side N
- KERNEL, 3: kernel side K
- STRIDE, 3: upsampling stride S (≥1)
- C_IN, 2: input channels
- C_OUT, 2: output channels
- INTEGER_WIDTH, 10 / FRACTION_WIDTH, 10: data format; W = sum
- KERNEL_BIT_WIDTH, 6: weight code width KB; [KB−1] sign, [KB−2] direction (1 = right shift), [KB−3:0] shift amount
- ACC_GUARD, 12: extra accumulator bits; ACC_W = W + 2^(KB−2) − 1 + ACC_GUARD
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  pixel beat valid
- in_ready  out  1  pixel beat accepted when in_valid & in_ready
- in_data  in  W  signed pixel, channel-major then raster order
- kernel_addr  out  clog2(C_OUT·C_IN·K·K)  weight index ((co·C_IN+ci)·K+ki)·K+kj
- kernel_data  in  KB  weight code, valid exactly 1 cycle after kernel_addr
- out_addr  in  clog2(C_OUT·O·O)  output index (co·O+r)·O+c
- out_data  out  W  saturated result, 1-cycle read latency
- done  out  1  result set valid

## Operation
- States: IDLE, LOAD, CLEAR, ADDR, READ, ACC, DONE.
- IDLE/DONE: in_ready=1. First accepted beat is stored at pixel 0, clears done, and enters LOAD.
- LOAD: in_ready=1. Beats are stored sequentially. After the C_IN·N·N-th beat, in_ready drops the next cycle and the FSM enters CLEAR.
- CLEAR: writes zero to one accumulator per cycle for C_OUT·O·O cycles, then enters ADDR with all loop indices at 0.
- Loop nest, outermost first: co, ci, i, j, ki, kj.
- ADDR: drive kernel_addr, the pixel address ci·N²+i·N+j, and the accumulator address (co·O+S·i+ki)·O+S·j+kj.
- READ: memory/ROM latency cycle.
- ACC: form the term t from pixel x and weight code w, then acc += t.
  - x is sign-extended to ACC_W and placed with FRACTION_WIDTH alignment preserved.
  - Direction 1 gives arithmetic right shift (floor); direction 0 gives left shift.
  - Negate if sign = 1.
  - Code {1, 0…0} (negative zero) is the zero weight: t = 0.
  - The accumulator wraps two's complement in ACC_W.
- After ACC: advance kj→ki→j→i→ci→co with carry. Return to ADDR, or to DONE after the last tap.
- DONE: done=1. out_data = acc[out_addr] saturated to [−2^(W−1), 2^(W−1)−1] of the Q(INTEGER_WIDTH.FRACTION_WIDTH) value.
- out_addr is ignored outside DONE, where out_data = 0.
- out_addr ≥ C_OUT·O·O: out_data = 0.

## Timing
- Reset values: in_ready=0 while reset is low, 1 in the first cycle after release (IDLE). done=0, kernel_addr=0, out_data=0. Loop indices are 0.
- Memories are not reset; CLEAR guarantees a correct result.
- Per tap: exactly 3 cycles (ADDR, READ, ACC). No tap pipelining.
- Compute latency from the last input beat: 1 + C_OUT·O·O + 3·C_OUT·C_IN·N²·K² cycles to done rising.
- Overlapping taps (K > S) accumulate correctly because read-modify-write completes within ACC before the next ADDR.
- in_valid outside IDLE/LOAD/DONE is ignored; no beat is lost, since in_ready=0.
- done falls in the same cycle the first beat of a new frame is accepted. Reads in that cycle return the old result.
- reset low mid-LOAD or mid-compute: immediate return to IDLE and done=0. A partial frame is discarded.
- Stalls: in_valid low during LOAD holds the count; there is no timeout.

## Test plan
- N=2, K=3, S=2, C_IN=C_OUT=1, pixels {1.0, 2.0, −1.0, 0.5}, all weights 000000 (×1).
  - Expect O=5.
  - out[0,2] = 1.0+2.0 = 3.0 (overlap).
  - out[2,2] = 1+2−1+0.5 = 2.5.
  - out[4,4] = 0.5.
- Weight codes 010001 (÷2), 100001 (×−2), 100000 (zero) on a single tap with x=−3.0.
  - Expect −1.5, +6.0, 0.0 respectively.
  - Also x = −2^−10 with ÷2 gives −2^−10 (floor).
- Saturation: pixel 500.0, weight ×4, K=S=1 gives out_data = 0x7FFFF. Pixel −500.0 gives 0x80000.
- C_IN=2, C_OUT=2: channel 0 all 1.0, channel 1 all 2.0, weight ×1 for (co0,ci0) and (co1,ci1) only, zero code elsewhere.
  - Plane 0 = 1.0 pattern, plane 1 = 2.0 pattern.
  - Verify kernel_addr order and the latency count.
- Back-to-back frames: second frame differs from the first; verify no residue from the first (CLEAR works) and that done drops on the first accepted beat.
- Reset asserted mid-compute, then a fresh frame: verify done=0 and in_ready=0 during reset, in_ready=1 the cycle after release, and a correct final result.
